// File: rtl/icache_data_ram_ctrl.sv
// Data SRAM sequencer for the L1.5 instruction cache: merges line refill writes
// and single-word fetch reads onto one single-port SRAM, with a skid-held read response.
module icache_data_ram_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 7,
    parameter int BEATS_PER_LINE = 4,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int CNT_W          = $clog2(BEATS_PER_LINE),
    parameter int LINE_W         = ADDR_WIDTH - CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  refill_valid_i,
    output logic                  refill_ready_o,
    input  logic [LINE_W-1:0]     refill_line_i,
    input  logic [DATA_WIDTH-1:0] refill_data_i,
    output logic                  refill_done_o,
    input  logic                  fetch_req_i,
    output logic                  fetch_gnt_o,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
    output logic                  fetch_rvalid_o,
    input  logic                  fetch_rready_i,
    output logic [DATA_WIDTH-1:0] fetch_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [BE_WIDTH-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                r_state, w_nextState;
    logic [CNT_W-1:0]      r_beatCnt, w_nextBeatCnt;
    logic [LINE_W-1:0]     r_line, w_nextLine;
    logic                  r_active;
    logic                  r_respPend;
    logic                  r_holdVld;
    logic [DATA_WIDTH-1:0] r_holdQ;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_lastAddr;
    logic [DATA_WIDTH-1:0] r_lastWdata;
    logic                  r_lastWe;

    logic                  w_write;
    logic                  w_lastBeat;
    logic                  w_gnt;
    logic                  w_rvalid;
    logic [ADDR_WIDTH-1:0] w_writeAddr;

    // r_active keeps every request off while reset is asserted and for the release cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_beatCnt   <= '0;
            r_line      <= '0;
            r_active    <= 1'b0;
            r_respPend  <= 1'b0;
            r_holdVld   <= 1'b0;
            r_holdQ     <= '0;
            r_done      <= 1'b0;
            r_lastAddr  <= '0;
            r_lastWdata <= '0;
            r_lastWe    <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_beatCnt  <= w_nextBeatCnt;
            r_line     <= w_nextLine;
            r_active   <= 1'b1;
            r_respPend <= w_gnt;
            r_done     <= w_lastBeat;
            if (r_respPend && !fetch_rready_i) begin
                r_holdVld <= 1'b1;
                r_holdQ   <= mem_rdata_i;
            end else if (fetch_rready_i) begin
                r_holdVld <= 1'b0;
            end
            if (mem_req_o) begin
                r_lastAddr  <= mem_addr_o;
                r_lastWdata <= mem_wdata_o;
                r_lastWe    <= mem_we_o;
            end
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextBeatCnt = r_beatCnt;
        w_nextLine    = r_line;
        w_write       = 1'b0;
        w_lastBeat    = 1'b0;
        w_writeAddr   = r_lastAddr;
        case (r_state)
            IDLE: begin
                if (r_active && refill_valid_i) begin
                    w_write       = 1'b1;
                    w_writeAddr   = {refill_line_i, {CNT_W{1'b0}}};
                    w_nextLine    = refill_line_i;
                    w_nextBeatCnt = CNT_W'(1);
                    w_nextState   = REFILL;
                end
            end
            REFILL: begin
                if (refill_valid_i) begin
                    w_write     = 1'b1;
                    w_writeAddr = {r_line, r_beatCnt};
                    if (r_beatCnt == CNT_W'(BEATS_PER_LINE - 1)) begin
                        w_lastBeat    = 1'b1;
                        w_nextBeatCnt = '0;
                        w_nextState   = IDLE;
                    end else begin
                        w_nextBeatCnt = r_beatCnt + 1'b1;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // A grant needs a free response slot: either nothing pending or it is being taken now
    always_comb begin
        w_rvalid = r_respPend | r_holdVld;
        w_gnt    = r_active & fetch_req_i & (r_state == IDLE) & ~refill_valid_i
                   & (~w_rvalid | fetch_rready_i);
    end

    always_comb begin
        refill_ready_o = r_active;
        refill_done_o  = r_done;
        fetch_gnt_o    = w_gnt;
        fetch_rvalid_o = w_rvalid;
        fetch_rdata_o  = r_respPend ? mem_rdata_i : r_holdQ;
        mem_req_o      = w_write | w_gnt;
        mem_be_o       = '1;
        mem_we_o       = r_lastWe;
        mem_addr_o     = r_lastAddr;
        mem_wdata_o    = r_lastWdata;
        if (w_write) begin
            mem_we_o    = 1'b1;
            mem_addr_o  = w_writeAddr;
            mem_wdata_o = refill_data_i;
        end else if (w_gnt) begin
            mem_we_o   = 1'b0;
            mem_addr_o = fetch_addr_i;
        end
    end

endmodule

// File: tb/tb_icache_data_ram_ctrl.sv
// Directed bench for icache_data_ram_ctrl: refills, fetches, response stalls,
// refill/fetch priority and reset in the middle of a refill, against a simple SRAM model.
module tb_icache_data_ram_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        refill_valid_i;
   logic        refill_ready_o;
   logic [4:0]  refill_line_i;
   logic [63:0] refill_data_i;
   logic        refill_done_o;
   logic        fetch_req_i;
   logic        fetch_gnt_o;
   logic [6:0]  fetch_addr_i;
   logic        fetch_rvalid_o;
   logic        fetch_rready_i;
   logic [63:0] fetch_rdata_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [6:0]  mem_addr_o;
   logic [63:0] mem_wdata_o;
   logic [7:0]  mem_be_o;
   logic [63:0] mem_rdata_i;

   logic [63:0] sram [128];
   logic [63:0] lineA [4];
   logic [63:0] lineB [4];
   logic [63:0] lineC [4];
   logic [63:0] lineD [4];
   logic [63:0] lineE [4];
   int checkCount = 0;
   int errorCount = 0;
   int doneCount  = 0;

   icache_data_ram_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .refill_valid_i(refill_valid_i),
      .refill_ready_o(refill_ready_o),
      .refill_line_i (refill_line_i),
      .refill_data_i (refill_data_i),
      .refill_done_o (refill_done_o),
      .fetch_req_i   (fetch_req_i),
      .fetch_gnt_o   (fetch_gnt_o),
      .fetch_addr_i  (fetch_addr_i),
      .fetch_rvalid_o(fetch_rvalid_o),
      .fetch_rready_i(fetch_rready_i),
      .fetch_rdata_o (fetch_rdata_o),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_be_o      (mem_be_o),
      .mem_rdata_i   (mem_rdata_i)
   );

   // 10-unit clock; inputs change on the falling edge
   always #5 clk = ~clk;

   // Single-port SRAM with one-cycle read latency
   always @(posedge clk) begin
      if (mem_req_o && mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
      if (mem_req_o && !mem_we_o) mem_rdata_i <= sram[mem_addr_o];
   end

   // Counts completed-line pulses over the whole run
   always @(negedge clk) begin
      if (refill_done_o) doneCount++;
   end

   // Every comparison of the bench is made through this task
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drives one cycle of inputs on the falling edge and settles combinational outputs
   task automatic applyStimulus(input logic rv, input logic [4:0] line, input logic [63:0] data,
                                input logic fr, input logic [6:0] faddr, input logic rr);
      @(negedge clk);
      refill_valid_i = rv;
      refill_line_i  = line;
      refill_data_i  = data;
      fetch_req_i    = fr;
      fetch_addr_i   = faddr;
      fetch_rready_i = rr;
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 7'd0, 1'b1);
   endtask

   task automatic refillBeat(input string tag, input logic [4:0] line, input logic [63:0] data,
                             input logic [6:0] expAddr);
      applyStimulus(1'b1, line, data, 1'b0, 7'd0, 1'b1);
      checkOutput({tag, "_req"}, 64'(mem_req_o), 64'd1);
      checkOutput({tag, "_we"}, 64'(mem_we_o), 64'd1);
      checkOutput({tag, "_addr"}, 64'(mem_addr_o), 64'(expAddr));
      checkOutput({tag, "_wdata"}, mem_wdata_o, data);
      checkOutput({tag, "_be"}, 64'(mem_be_o), 64'hFF);
      checkOutput({tag, "_done"}, 64'(refill_done_o), 64'd0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ready"}, 64'(refill_ready_o), 64'd0);
      checkOutput({tag, "_done"}, 64'(refill_done_o), 64'd0);
      checkOutput({tag, "_gnt"}, 64'(fetch_gnt_o), 64'd0);
      checkOutput({tag, "_rvalid"}, 64'(fetch_rvalid_o), 64'd0);
      checkOutput({tag, "_rdata"}, fetch_rdata_o, 64'd0);
      checkOutput({tag, "_req"}, 64'(mem_req_o), 64'd0);
      checkOutput({tag, "_we"}, 64'(mem_we_o), 64'd0);
   endtask

   // Fetch issue cycle and its response cycle, with the consumer always ready
   task automatic fetchWord(input string tag, input logic [6:0] addr, input logic [63:0] expData);
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, addr, 1'b1);
      checkOutput({tag, "_gnt"}, 64'(fetch_gnt_o), 64'd1);
      checkOutput({tag, "_addr"}, 64'(mem_addr_o), 64'(addr));
      checkOutput({tag, "_we"}, 64'(mem_we_o), 64'd0);
      idleCycle();
      checkOutput({tag, "_rvalid"}, 64'(fetch_rvalid_o), 64'd1);
      checkOutput({tag, "_rdata"}, fetch_rdata_o, expData);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         lineA[i] = 64'hA0A0_0000_0000_0000 + 64'(i);
         lineB[i] = 64'hB1B1_0000_0000_0000 + 64'(i);
         lineC[i] = 64'hC2C2_0000_0000_0000 + 64'(i);
         lineD[i] = 64'hD3D3_0000_0000_0000 + 64'(i);
         lineE[i] = 64'hE4E4_0000_0000_0000 + 64'(i);
      end
      for (int i = 0; i < 128; i++) sram[i] = 64'd0;
      mem_rdata_i    = 64'd0;
      rst_n          = 1'b0;
      refill_valid_i = 1'b0;
      refill_line_i  = 5'd0;
      refill_data_i  = 64'd0;
      fetch_req_i    = 1'b0;
      fetch_addr_i   = 7'd0;
      fetch_rready_i = 1'b1;

      // Reset with requests present: nothing may reach the SRAM
      repeat (2) @(negedge clk);
      refill_valid_i = 1'b1;
      fetch_req_i    = 1'b1;
      #1;
      checkResetOutputs("rst0");
      @(negedge clk);
      rst_n          = 1'b1;
      refill_valid_i = 1'b0;
      fetch_req_i    = 1'b0;
      idleCycle();
      checkOutput("ready_after_rst", 64'(refill_ready_o), 64'd1);

      // Refill line 3 back to back
      for (int i = 0; i < 4; i++) refillBeat("refA", 5'd3, lineA[i], 7'(12 + i));
      idleCycle();
      checkOutput("refA_done", 64'(refill_done_o), 64'd1);
      checkOutput("refA_idle_req", 64'(mem_req_o), 64'd0);
      checkOutput("refA_hold_addr", 64'(mem_addr_o), 64'd15);
      checkOutput("refA_hold_wdata", mem_wdata_o, lineA[3]);
      checkOutput("refA_hold_we", 64'(mem_we_o), 64'd1);
      idleCycle();
      checkOutput("refA_done_once", 64'(refill_done_o), 64'd0);

      // Single fetch
      fetchWord("f13", 7'd13, lineA[1]);
      idleCycle();
      checkOutput("f13_rvalid_drop", 64'(fetch_rvalid_o), 64'd0);

      // Back-to-back fetches 12,13,14
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 7'(12 + i), 1'b1);
         checkOutput("b2b_gnt", 64'(fetch_gnt_o), 64'd1);
         checkOutput("b2b_addr", 64'(mem_addr_o), 64'(12 + i));
         if (i > 0) begin
            checkOutput("b2b_rvalid", 64'(fetch_rvalid_o), 64'd1);
            checkOutput("b2b_rdata", fetch_rdata_o, lineA[i - 1]);
         end
      end
      idleCycle();
      checkOutput("b2b_last_rvalid", 64'(fetch_rvalid_o), 64'd1);
      checkOutput("b2b_last_rdata", fetch_rdata_o, lineA[2]);
      idleCycle();
      checkOutput("b2b_rvalid_drop", 64'(fetch_rvalid_o), 64'd0);

      // Stalled response while line 0 refills alongside
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 7'd14, 1'b0);
      checkOutput("stall_gnt0", 64'(fetch_gnt_o), 64'd1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'd0, lineB[i], 1'b1, 7'd14, 1'b0);
         checkOutput("stall_gnt", 64'(fetch_gnt_o), 64'd0);
         checkOutput("stall_rvalid", 64'(fetch_rvalid_o), 64'd1);
         checkOutput("stall_rdata", fetch_rdata_o, lineA[2]);
         checkOutput("stall_wr_addr", 64'(mem_addr_o), 64'(i));
         checkOutput("stall_wr_we", 64'(mem_we_o), 64'd1);
      end
      applyStimulus(1'b1, 5'd0, lineB[3], 1'b1, 7'd14, 1'b1);
      checkOutput("stall_acc_gnt", 64'(fetch_gnt_o), 64'd0);
      checkOutput("stall_acc_rdata", fetch_rdata_o, lineA[2]);
      checkOutput("stall_acc_addr", 64'(mem_addr_o), 64'd3);
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 7'd14, 1'b1);
      checkOutput("stall_after_done", 64'(refill_done_o), 64'd1);
      checkOutput("stall_after_gnt", 64'(fetch_gnt_o), 64'd1);
      checkOutput("stall_after_rvalid", 64'(fetch_rvalid_o), 64'd0);
      idleCycle();
      checkOutput("stall_refetch_rdata", fetch_rdata_o, lineA[2]);

      // Refill beats outrank a fetch raised in the same cycle
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 5'd1, lineC[i], 1'b1, 7'd12, 1'b1);
         checkOutput("prio_gnt", 64'(fetch_gnt_o), 64'd0);
         checkOutput("prio_we", 64'(mem_we_o), 64'd1);
         checkOutput("prio_addr", 64'(mem_addr_o), 64'(4 + i));
      end
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 7'd12, 1'b1);
      checkOutput("prio_done", 64'(refill_done_o), 64'd1);
      checkOutput("prio_late_gnt", 64'(fetch_gnt_o), 64'd1);
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 7'd2, 1'b1);
      checkOutput("prio_rdata12", fetch_rdata_o, lineA[0]);
      applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 7'd5, 1'b1);
      checkOutput("lineB2_rdata", fetch_rdata_o, lineB[2]);
      idleCycle();
      checkOutput("lineC1_rdata", fetch_rdata_o, lineC[1]);

      // Reset after two beats of line 5, then refill it again with a gap
      refillBeat("refD0", 5'd5, lineD[0], 7'd20);
      refillBeat("refD1", 5'd5, lineD[1], 7'd21);
      @(negedge clk);
      rst_n          = 1'b0;
      refill_valid_i = 1'b1;
      fetch_req_i    = 1'b1;
      #1;
      checkResetOutputs("rst1");
      @(negedge clk);
      rst_n          = 1'b1;
      refill_valid_i = 1'b0;
      fetch_req_i    = 1'b0;
      idleCycle();
      refillBeat("refE0", 5'd5, lineE[0], 7'd20);
      idleCycle();
      checkOutput("gap_req", 64'(mem_req_o), 64'd0);
      checkOutput("gap_done", 64'(refill_done_o), 64'd0);
      refillBeat("refE1", 5'd9, lineE[1], 7'd21);
      refillBeat("refE2", 5'd9, lineE[2], 7'd22);
      refillBeat("refE3", 5'd9, lineE[3], 7'd23);
      idleCycle();
      checkOutput("refE_done", 64'(refill_done_o), 64'd1);
      idleCycle();
      checkOutput("refE_done_once", 64'(refill_done_o), 64'd0);
      fetchWord("f21", 7'd21, lineE[1]);
      fetchWord("f13_again", 7'd13, lineA[1]);
      idleCycle();
      checkOutput("done_pulse_total", 64'(doneCount), 64'd4);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/icache_data_ram_ctrl.md
Name: icache_data_ram_ctrl

Overview:
- Initiator-side sequencer for the L1.5 instruction-cache data SRAM wrapper. It drives the single-port req/we/addr/wdata/be interface and consumes its one-cycle-latency rdata.
- Arbitrates between two sources:
  - a refill beat stream that writes whole cache lines into consecutive words;
  - a fetch port that reads single words and returns them on a valid/ready response channel.
- Sits between the cache refill/lookup logic and the data SRAM wrapper.

Parameters:
- DATA_WIDTH, 64, SRAM word width in bits.
- ADDR_WIDTH, 7, SRAM word address width (2**ADDR_WIDTH words).
- BEATS_PER_LINE, 4, words per cache line; power of 2, at least 2.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.
- Derived: LINE_W = ADDR_WIDTH - log2(BEATS_PER_LINE).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- refill_valid_i  in  1  refill beat valid.
- refill_ready_o  out  1  refill beat accepted when high together with valid.
- refill_line_i  in  LINE_W  target line index; sampled on the first beat of a line only.
- refill_data_i  in  DATA_WIDTH  beat data.
- refill_done_o  out  1  one-cycle pulse, cycle after the last beat's write.
- fetch_req_i  in  1  read request.
- fetch_gnt_o  out  1  read request granted this cycle.
- fetch_addr_i  in  ADDR_WIDTH  read word address.
- fetch_rvalid_o  out  1  read data valid.
- fetch_rready_i  in  1  consumer accepts read data.
- fetch_rdata_o  out  DATA_WIDTH  read data.
- mem_req_o  out  1  SRAM request.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  ADDR_WIDTH  SRAM address.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_be_o  out  BE_WIDTH  SRAM byte enables.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after a read req.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE; beat_cnt, line_q, resp_pend, hold_vld and hold_q clear.
  - refill_ready_o=0, refill_done_o=0, fetch_gnt_o=0, fetch_rvalid_o=0, fetch_rdata_o=0, mem_req_o=0, mem_we_o=0.
- FSM states: IDLE and REFILL.
- IDLE:
  - refill_valid_i=1 → write beat 0 to address {refill_line_i, 0}, capture line_q, set beat_cnt=1, go to REFILL.
  - Refill has priority over a fetch in the same cycle.
- REFILL:
  - Each accepted beat writes {line_q, beat_cnt} and increments beat_cnt.
  - On beat BEATS_PER_LINE-1: write it, clear beat_cnt, return to IDLE, pulse refill_done_o next cycle.
  - Gaps (valid low) are allowed and do not advance beat_cnt.
- refill_ready_o = 1 whenever out of reset. One SRAM write per cycle, no back-pressure.
- Write cycle: mem_req_o=1, mem_we_o=1, mem_be_o all-ones, mem_wdata_o=refill_data_i (combinational).
- fetch_gnt_o = fetch_req_i & state==IDLE & !refill_valid_i & (!fetch_rvalid_o | fetch_rready_i).
  - No fetch is granted between the first and last beat of a line.
- Fetch grant cycle: mem_req_o=1, mem_we_o=0, mem_addr_o=fetch_addr_i, mem_be_o all-ones.
- Response pipeline:
  - A grant in cycle t sets resp_pend for cycle t+1.
  - In t+1: fetch_rvalid_o=1, fetch_rdata_o=mem_rdata_i (bypass).
  - If fetch_rready_i=0 in t+1: mem_rdata_i is captured into hold_q and hold_vld set. Subsequent cycles drive hold_q until the response is accepted.
  - fetch_rvalid_o = resp_pend | hold_vld. Data stays stable while valid and not ready.
  - On acceptance, hold_vld clears, unless a new grant in the same cycle sets resp_pend.
- Throughput: one fetch per cycle back-to-back while fetch_rready_i=1. Latency is grant to rvalid = 1 cycle.
- A refill write in the cycle after a grant does not disturb the bypassed read: that data is either consumed or captured in that cycle.
- When no request is issued: mem_req_o=0. mem_addr_o, mem_wdata_o and mem_we_o hold their last values.
- Reset mid-refill: the partial line is left in the SRAM and beat_cnt restarts at 0. The tag logic upstream must treat that line as invalid.
- A fetch address within the line being refilled is not special-cased; the block before the first beat or after done is consistent.

Test Plan:
- Reset, then refill line 3 (BEATS_PER_LINE=4, data A0..A3, no gaps) → mem writes to addresses 12,13,14,15 on consecutive cycles; refill_done_o pulses once, the cycle after address 15.
- Fetch addr 13 with rready=1 after the refill → gnt in cycle t; rvalid=1 with rdata=A1 in t+1.
- Back-to-back fetches of 12,13,14 with rready held 1 → gnt on three consecutive cycles; rvalid high three cycles with A0, A1, A2.
- Fetch addr 14 with rready=0 for 3 cycles, while a refill of line 0 runs in parallel → rdata holds A2 stable for all 3 cycles; no further gnt until rready=1; line 0 writes proceed.
- refill_valid_i and fetch_req_i asserted in the same IDLE cycle → write issued, gnt=0; fetch granted only after the 4th beat.
- Assert rst_n=0 after beat 1 of line 5, then refill line 5 again → all outputs 0 during reset; the new refill writes 20,21,22,23; exactly one done pulse.
